ntsc_genlock_ctrl: RTL and testbench

Horizontal/vertical genlock controller for the NTSC timing generator. Measures the period of the source `hsync_in` and qualifies lock with a four-state machine. While locked, it issues one-cycle counter-resync pulses (`h_reset`, `v_reset`) so the free-running timing generator stays phase-aligned to the source. During short sync dropouts it holds over on the generator's own flywheel. It sits between the source sync inputs and the timing generator's counter-load inputs.

---
 rtl/ntsc_genlock_ctrl.sv | 157 +++++++++++++++
 tb/tb_ntsc_genlock_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntsc_genlock_ctrl.sv
// Genlock controller: measures source H period, qualifies lock, and emits counter-resync pulses.
// Latency: a sync edge or timeout seen in cycle T updates every output at T+1.
// No backpressure: free-running sync inputs, one-cycle pulse outputs.
module ntsc_genlock_ctrl #(
  parameter int H_TOTAL    = 228,
  parameter int TOL        = 2,
  parameter int LOCK_COUNT = 8,
  parameter int MISS_LIMIT = 4
) (
  input  logic       clk_pixel,
  input  logic       rst,
  input  logic       enable,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic       h_reset,
  output logic       v_reset,
  output logic       locked,
  output logic       holdover,
  output logic [1:0] state,
  output logic [8:0] last_period
);

  localparam logic [1:0] SEARCH   = 2'd0;
  localparam logic [1:0] VERIFY   = 2'd1;
  localparam logic [1:0] LOCKED   = 2'd2;
  localparam logic [1:0] HOLDOVER = 2'd3;

  localparam logic [8:0] WIN_LO = 9'(H_TOTAL - TOL);
  localparam logic [8:0] WIN_HI = 9'(H_TOTAL + TOL);
  localparam logic [8:0] TMO    = 9'(H_TOTAL + TOL + 1);
  // Reload lands the counter where it would be had the nominal edge arrived.
  localparam logic [8:0] RELOAD = 9'(TOL + 2);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  logic          hs_d, vs_d, v_pend;
  logic [8:0]    pcnt;
  logic [GW-1:0] good_cnt;
  logic [MW-1:0] miss_cnt;

  logic          rise, vrise, measured, in_win, early, hold_mode, timeout;
  logic [1:0]    st_n;
  logic [8:0]    pcnt_n;
  logic [GW-1:0] good_n;
  logic [MW-1:0] miss_n;
  logic          hr_n, vr_n, vp_n, lp_upd;

  assign rise      = hsync_in & ~hs_d;
  assign vrise     = vsync_in & ~vs_d;
  // A zero count means no earlier edge, so that edge carries no period.
  assign measured  = rise && (pcnt != 9'd0);
  assign in_win    = measured && (pcnt >= WIN_LO) && (pcnt <= WIN_HI);
  assign early     = measured && (pcnt < WIN_LO);
  assign hold_mode = (state == LOCKED) || (state == HOLDOVER);
  // In the lock states a timeout overrides any coincident edge.
  assign timeout   = hold_mode && (pcnt == TMO);

  // Next-state, period counter and pulse decisions.
  always_comb begin
    st_n   = state;
    good_n = good_cnt;
    miss_n = miss_cnt;
    pcnt_n = pcnt;
    hr_n   = 1'b0;
    lp_upd = 1'b0;
    if ((pcnt != 9'd0) && (pcnt != 9'd511)) pcnt_n = pcnt + 9'd1;
    case (state)
      SEARCH: begin
        if (rise) pcnt_n = 9'd1;
        lp_upd = measured;
        if (in_win) begin
          st_n   = VERIFY;
          good_n = GW'(1);
        end
      end
      VERIFY: begin
        if (rise) pcnt_n = 9'd1;
        lp_upd = measured;
        if (in_win) begin
          if (good_cnt == GW'(LOCK_COUNT - 1)) begin
            st_n   = LOCKED;
            hr_n   = 1'b1;
            good_n = '0;
          end else begin
            good_n = good_cnt + 1'b1;
          end
        end else if (measured || (pcnt == TMO)) begin
          st_n   = SEARCH;
          good_n = '0;
        end
      end
      default: begin
        if (timeout) begin
          pcnt_n = RELOAD;
          if (miss_cnt == MW'(MISS_LIMIT - 1)) begin
            st_n   = SEARCH;
            miss_n = '0;
            good_n = '0;
          end else begin
            st_n   = HOLDOVER;
            miss_n = miss_cnt + 1'b1;
          end
        end else if (in_win) begin
          pcnt_n = 9'd1;
          lp_upd = 1'b1;
          st_n   = LOCKED;
          miss_n = '0;
          hr_n   = 1'b1;
        end else if (early) begin
          // Equalizing/serration pulses: reported, but the line phase is kept.
          lp_upd = 1'b1;
        end
      end
    endcase
  end

  // Vertical resync rides on the next line resync; it is only armed while locked.
  always_comb begin
    vr_n = hr_n && (v_pend || vrise);
    if (hr_n)                           vp_n = 1'b0;
    else if ((state == LOCKED) && vrise) vp_n = 1'b1;
    else                                vp_n = v_pend;
    if (st_n != LOCKED) vp_n = 1'b0;
  end

  // State and registered outputs; disable acts exactly like reset.
  always_ff @(posedge clk_pixel) begin
    if (rst || !enable) begin
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      v_pend      <= 1'b0;
      pcnt        <= '0;
      good_cnt    <= '0;
      miss_cnt    <= '0;
      state       <= SEARCH;
      h_reset     <= 1'b0;
      v_reset     <= 1'b0;
      locked      <= 1'b0;
      holdover    <= 1'b0;
      last_period <= '0;
    end else begin
      hs_d        <= hsync_in;
      vs_d        <= vsync_in;
      v_pend      <= vp_n;
      pcnt        <= pcnt_n;
      good_cnt    <= good_n;
      miss_cnt    <= miss_n;
      state       <= st_n;
      h_reset     <= hr_n;
      v_reset     <= vr_n;
      locked      <= (st_n == LOCKED);
      holdover    <= (st_n == HOLDOVER);
      if (lp_upd) last_period <= pcnt;
    end
  end

endmodule

// File: tb/tb_ntsc_genlock_ctrl.sv
// Bench for ntsc_genlock_ctrl: time-referenced reference model feeding a scoreboard.
// Expected pulses/state changes are queued at stimulus time and popped by a monitor.
// Stimulus is directed scenarios followed by randomized lines, gaps and vsync.
module tb_ntsc_genlock_ctrl;

  localparam int H  = 228;
  localparam int T  = 2;
  localparam int LC = 8;
  localparam int ML = 4;

  logic       clk_pixel = 1'b0;
  logic       rst = 1'b1, enable = 1'b1, hsync_in = 1'b0, vsync_in = 1'b0;
  logic       h_reset, v_reset, locked, holdover;
  logic [1:0] state;
  logic [8:0] last_period;

  ntsc_genlock_ctrl #(.H_TOTAL(H), .TOL(T), .LOCK_COUNT(LC), .MISS_LIMIT(ML)) dut (
    .clk_pixel(clk_pixel), .rst(rst), .enable(enable),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .h_reset(h_reset), .v_reset(v_reset), .locked(locked), .holdover(holdover),
    .state(state), .last_period(last_period)
  );

  always #5 clk_pixel = ~clk_pixel;

  int cyc = 0;
  always @(posedge clk_pixel) cyc <= cyc + 1;

  int checks = 0, passes = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_SEARCH = 0, M_VERIFY = 1, M_LOCKED = 2, M_HOLD = 3} mst_t;
  typedef struct { int tag; bit v; int lp; } hexp_t;
  typedef struct { int tag; int st; } sexp_t;
  hexp_t hq[$];
  sexp_t sq[$];

  mst_t m_st = M_SEARCH;
  bit   m_have_ref = 0, m_vpend = 0, m_hs_p = 0, m_vs_p = 0;
  int   m_ref = 0, m_good = 0, m_miss = 0, m_lastp = 0;

  // The model tracks the time of the nominal line start instead of a counter.
  task automatic model(input bit hs, input bit vs, input bit clr, input int t);
    mst_t nst;
    bit hr, rise, vrise;
    int age, per;
    if (clr) begin
      if (m_st != M_SEARCH) sq.push_back('{t + 1, 0});
      m_st = M_SEARCH; m_have_ref = 0; m_good = 0; m_miss = 0;
      m_vpend = 0; m_hs_p = 0; m_vs_p = 0; m_lastp = 0;
      return;
    end
    hr = 0;
    rise  = hs && !m_hs_p;
    vrise = vs && !m_vs_p;
    m_hs_p = hs; m_vs_p = vs;
    age = m_have_ref ? t - m_ref : 0;
    per = (age > 511) ? 511 : age;
    nst = m_st;
    if (m_st == M_LOCKED || m_st == M_HOLD) begin
      if (age == H + T + 1) begin
        m_ref += H;
        m_miss++;
        if (m_miss >= ML) begin nst = M_SEARCH; m_miss = 0; m_good = 0; end
        else nst = M_HOLD;
      end else if (rise) begin
        m_lastp = per;
        if (per >= H - T) begin hr = 1; m_ref = t; nst = M_LOCKED; m_miss = 0; end
      end
    end else if (rise) begin
      if (m_have_ref) begin
        m_lastp = per;
        if (per >= H - T && per <= H + T) begin
          if (m_st == M_SEARCH) begin nst = M_VERIFY; m_good = 1; end
          else begin
            m_good++;
            if (m_good == LC) begin nst = M_LOCKED; hr = 1; m_good = 0; end
          end
        end else if (m_st == M_VERIFY) begin
          nst = M_SEARCH; m_good = 0;
        end
      end
      m_ref = t; m_have_ref = 1;
    end else if (m_st == M_VERIFY && age == H + T + 1) begin
      nst = M_SEARCH; m_good = 0;
    end
    if (hr) begin
      hq.push_back('{t + 1, m_vpend || vrise, m_lastp});
      m_vpend = 0;
    end else if (m_st == M_LOCKED && vrise) m_vpend = 1;
    if (nst != M_LOCKED) m_vpend = 0;
    if (nst != m_st) sq.push_back('{t + 1, int'(nst)});
    m_st = nst;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick(input bit hs, input bit vs);
    hsync_in = hs;
    vsync_in = vs;
    model(hs, vs, rst || !enable, cyc);
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic line(input int per, input int w, input int vs_at);
    for (int i = 0; i < per; i++)
      tick(i < w, (vs_at >= 0) && (i >= vs_at) && (i < vs_at + 3));
  endtask

  task automatic eq_line(input int w);
    for (int i = 0; i < H; i++) tick((i < w) || (i >= 114 && i < 114 + w), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_h_reset"}, int'(h_reset), 0);
    chk({nm, "_v_reset"}, int'(v_reset), 0);
    chk({nm, "_locked"}, int'(locked), 0);
    chk({nm, "_holdover"}, int'(holdover), 0);
    chk({nm, "_state"}, int'(state), 0);
    chk({nm, "_last_period"}, int'(last_period), 0);
  endtask

  task automatic clear_pulse(input bit use_en);
    if (use_en) enable = 1'b0; else rst = 1'b1;
    tick(1'b0, 1'b0);
    rst = 1'b0; enable = 1'b1;
    @(negedge clk_pixel);
    check_zero(use_en ? "enable_clear" : "rst_clear");
  endtask

  function automatic int rw();
    return $urandom_range(1, 8);
  endfunction

  // ---------------- monitor ----------------
  bit    mon_en = 0;
  int    prev_st = 0;
  hexp_t he;
  sexp_t se;

  always @(negedge clk_pixel) begin
    if (mon_en) begin
      while (hq.size() > 0 && hq[0].tag < cyc) begin
        chk("h_reset_missing", 0, 1);
        void'(hq.pop_front());
      end
      while (sq.size() > 0 && sq[0].tag < cyc) begin
        chk("state_change_missing", int'(state), sq[0].st);
        void'(sq.pop_front());
      end
      if (h_reset) begin
        if (hq.size() == 0 || hq[0].tag != cyc) chk("h_reset_unexpected", 1, 0);
        else begin
          he = hq.pop_front();
          chk("v_reset", int'(v_reset), int'(he.v));
          chk("last_period", int'(last_period), he.lp);
        end
      end else if (v_reset) chk("v_reset_without_h", 1, 0);
      if (int'(state) != prev_st) begin
        if (sq.size() == 0 || sq[0].tag != cyc) chk("state_unexpected", int'(state), prev_st);
        else begin
          se = sq.pop_front();
          chk("state", int'(state), se.st);
          chk("locked", int'(locked), int'(se.st == 2));
          chk("holdover", int'(holdover), int'(se.st == 3));
        end
      end
      prev_st = int'(state);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    rst = 1'b1;
    repeat (4) tick(1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk_pixel);
    check_zero("reset");
    mon_en = 1;

    // Acquisition: the 9th rise locks.
    repeat (8) line(H, rw(), -1);
    chk("verify_before_9th", int'(state), 1);
    line(H, rw(), -1);
    chk("lock_acq", int'(state), 2);

    // Tolerance edges keep lock.
    line(226, rw(), -1);
    line(230, rw(), -1);
    repeat (8) line($urandom_range(H - T, H + T), rw(), -1);
    chk("tolerance_lock", int'(state), 2);

    // Equalizing pulses mid-line are ignored.
    repeat (3) eq_line(rw());
    line(H, rw(), -1);
    chk("equalizing_lock", int'(state), 2);

    // Vertical: mid-line vsync, then vsync coincident with a line edge.
    line(H, rw(), $urandom_range(20, 200));
    line(H, rw(), -1);
    line(H, rw(), 0);
    line(H, rw(), -1);

    // Short dropout: holdover at nominal+3, resume on phase after 2 misses.
    idle(3);
    chk("before_timeout", int'(state), 2);
    idle(1);
    chk("holdover_entry", int'(state), 3);
    idle(2 * H - 4);
    chk("holdover_flag", int'(holdover), 1);
    line(H, rw(), -1);
    chk("resume_lock", int'(state), 2);
    line(H, rw(), -1);

    // Long dropout drops lock after MISS_LIMIT missed lines.
    idle(5 * H);
    chk("dropout_search", int'(state), 0);
    line(H, rw(), 100);
    line(H, rw(), 60);
    chk("vsync_unlocked_verify", int'(state), 1);

    // Out-of-window periods in VERIFY.
    line(231, rw(), -1);
    line(H, rw(), -1);
    chk("late_to_search", int'(state), 0);
    line(H, rw(), -1);
    chk("reverify", int'(state), 1);
    line(225, rw(), -1);
    line(H, rw(), -1);
    chk("early_to_search", int'(state), 0);

    // Clear while locked via rst, then via enable; each needs 9 fresh edges.
    clear_pulse(1'b0);
    repeat (9) line(H, rw(), -1);
    chk("lock_before_rst", int'(state), 2);
    line(H, rw(), -1);
    clear_pulse(1'b0);
    repeat (8) line(H, rw(), -1);
    chk("no_lock_after_8", int'(state), 1);
    line(H, rw(), -1);
    chk("relock_after_rst", int'(state), 2);
    clear_pulse(1'b1);
    repeat (9) line(H, rw(), -1);
    chk("relock_after_enable", int'(state), 2);

    // Randomized mix.
    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k <= 5)
        line($urandom_range(H - 4, H + 4), rw(),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 90)) : -1);
      else if (k == 6) eq_line(rw());
      else if (k == 7) idle($urandom_range(1, 700));
      else if (k == 8) line($urandom_range(100, 240), rw(), -1);
      else line(H, rw(), -1);
    end

    idle(600);
    @(negedge clk_pixel);
    chk("h_queue_drained", hq.size(), 0);
    chk("state_queue_drained", sq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
